// File: rtl/systolic_cluster_scheduler_pkg.sv
// Shared types and width helpers for the systolic cluster scheduler.
// Holds the controller and per-array state enums, plus the width helper
// and the default width constants used by the scheduler and its users.
package systolic_sched_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, COMPUTE, DRAIN, READ} sched_state_t;
    typedef enum logic [1:0] {FREE, BUSY, HELD} arr_state_t;

    // $clog2 clamped to at least one bit so single-entry configs stay legal.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_NUM_ARRAYS = 8;
    localparam int unsigned REQ_BITS       = clog2_min1(DEF_NUM_REQ);
    localparam int unsigned ARR_BITS       = clog2_min1(DEF_NUM_ARRAYS);

endpackage

// File: rtl/systolic_cluster_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr.
// Ports: req (request vector), ptr (search start), grant (one-hot),
//        grant_idx (index of the granted requester, 0 when none).
module rr_arbiter
    import systolic_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned RB     = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [RB-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [RB-1:0]      grant_idx
);

    logic          found;
    int unsigned   pos;
    logic [RB-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            // Wrap the search position without a modulo on odd sizes.
            pos = 32'(ptr) + i;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            idx = RB'(pos);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/systolic_cluster_scheduler.sv
// Job scheduler/sequencer for the multi-array systolic cluster.
// Ports: clk/reset (sync, active-low); req_valid/req_k_len/req_ready job
// requests; op_valid/op_ready/data_owner operand flow; cl_* cluster control
// pins and cl_array_ready; done_* completion pulse; rd_* result reads;
// rel_* array release; array_busy per-array BUSY-or-HELD flags.
module systolic_cluster_scheduler
    import systolic_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
    parameter int unsigned NUM_ARRAYS   = DEF_NUM_ARRAYS,
    parameter int unsigned K_BITS       = 8,
    parameter int unsigned DRAIN_CYCLES = 2,
    localparam int unsigned RB          = clog2_min1(NUM_REQ),
    localparam int unsigned AB          = clog2_min1(NUM_ARRAYS),
    localparam int unsigned DW          = clog2_min1(DRAIN_CYCLES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*K_BITS-1:0] req_k_len,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      op_valid,
    output logic                      op_ready,
    output logic [RB-1:0]             data_owner,
    output logic                      cl_enable,
    output logic [AB-1:0]             cl_array_select,
    output logic                      cl_clear_acc,
    output logic                      cl_load_weights,
    output logic                      cl_compute_enable,
    output logic                      cl_broadcast_mode,
    input  logic [NUM_ARRAYS-1:0]     cl_array_ready,
    output logic                      done_valid,
    output logic [RB-1:0]             done_req,
    output logic [AB-1:0]             done_array,
    input  logic                      rd_valid,
    input  logic [AB-1:0]             rd_array,
    output logic                      rd_ready,
    output logic                      rd_err,
    input  logic                      rel_valid,
    input  logic [AB-1:0]             rel_array,
    output logic [NUM_ARRAYS-1:0]     array_busy
);

    sched_state_t  state, state_nxt;
    arr_state_t    arr_st [NUM_ARRAYS];
    logic [RB-1:0] rr_ptr, owner;
    logic [K_BITS-1:0] k_rem, win_k;
    logic [AB-1:0] sel, rd_sel, free_idx;
    logic [DW-1:0] drain_cnt;
    logic          free_any, grant_fire, rd_hit, drain_done;
    logic [NUM_REQ-1:0] arb_grant;
    logic [RB-1:0]      arb_idx;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Lowest-index FREE array, winner's k_len and the busy view.
    always_comb begin
        free_any   = 1'b0;
        free_idx   = '0;
        win_k      = '0;
        array_busy = '0;
        for (int unsigned i = NUM_ARRAYS; i > 0; i--) begin
            if (arr_st[i-1] == FREE) begin
                free_any = 1'b1;
                free_idx = AB'(i - 1);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) win_k = req_k_len[i*K_BITS +: K_BITS];
        end
        for (int unsigned i = 0; i < NUM_ARRAYS; i++) begin
            array_busy[i] = (arr_st[i] != FREE);
        end
    end

    // A pending read always pre-empts a new grant, even when it errors.
    always_comb begin
        rd_hit     = (state == IDLE) && rd_valid && (arr_st[rd_array] == HELD);
        grant_fire = reset && (state == IDLE) && !rd_valid && (|req_valid) && free_any;
        drain_done = (state == DRAIN) && (32'(drain_cnt) + 32'd1 >= DRAIN_CYCLES)
                     && cl_array_ready[sel];
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_valid)        state_nxt = rd_hit ? READ : IDLE;
                else if (grant_fire) state_nxt = CLEAR;
            end
            CLEAR: state_nxt = LOAD;
            LOAD: begin
                if (op_valid) state_nxt = (k_rem == '0) ? DRAIN : COMPUTE;
            end
            COMPUTE: begin
                if (op_valid && (k_rem == K_BITS'(1))) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_done) state_nxt = IDLE;
            end
            READ:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr    <= '0;
            owner     <= '0;
            k_rem     <= '0;
            sel       <= '0;
            rd_sel    <= '0;
            drain_cnt <= '0;
            for (int unsigned i = 0; i < NUM_ARRAYS; i++) arr_st[i] <= FREE;
        end else begin
            if (grant_fire) begin
                owner            <= arb_idx;
                k_rem            <= win_k;
                sel              <= free_idx;
                rr_ptr           <= (32'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
                arr_st[free_idx] <= BUSY;
            end
            if (state == IDLE && rd_valid) rd_sel <= rd_array;
            if (state == COMPUTE && op_valid) k_rem <= k_rem - 1'b1;
            if (state == DRAIN) begin
                if (32'(drain_cnt) < DRAIN_CYCLES) drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end
            if (drain_done) arr_st[sel] <= HELD;
            // Only HELD arrays can be released; the freed slot is seen next cycle.
            if (rel_valid && arr_st[rel_array] == HELD) arr_st[rel_array] <= FREE;
        end
    end

    always_comb begin
        req_ready         = '0;
        op_ready          = 1'b0;
        data_owner        = '0;
        cl_enable         = 1'b0;
        cl_array_select   = '0;
        cl_clear_acc      = 1'b0;
        cl_load_weights   = 1'b0;
        cl_compute_enable = 1'b0;
        cl_broadcast_mode = 1'b0;
        done_valid        = 1'b0;
        done_req          = '0;
        done_array        = '0;
        rd_ready          = 1'b0;
        rd_err            = 1'b0;
        case (state)
            IDLE: begin
                if (grant_fire) req_ready = arb_grant;
                rd_err = reset && rd_valid && !rd_hit;
            end
            CLEAR: begin
                cl_enable       = 1'b1;
                cl_clear_acc    = 1'b1;
                cl_array_select = sel;
                data_owner      = owner;
            end
            LOAD: begin
                op_ready        = 1'b1;
                cl_load_weights = op_valid;
                cl_enable       = op_valid;
                cl_array_select = sel;
                data_owner      = owner;
            end
            COMPUTE: begin
                op_ready          = 1'b1;
                cl_compute_enable = op_valid;
                cl_enable         = 1'b1;
                cl_array_select   = sel;
                data_owner        = owner;
            end
            DRAIN: begin
                cl_enable       = 1'b1;
                cl_array_select = sel;
                done_valid      = drain_done;
                if (drain_done) begin
                    done_req   = owner;
                    done_array = sel;
                end
            end
            READ: begin
                cl_array_select = rd_sel;
                rd_ready        = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_systolic_cluster_scheduler.sv
// Self-checking bench for systolic_cluster_scheduler: table-driven jobs,
// hand-written corner sequences and randomized traffic against a
// transaction-level model of array ownership and round-robin order.
module tb_systolic_cluster_scheduler;
    import systolic_sched_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned NA = 8;
    localparam int unsigned KB = 8;
    localparam int DC = 2;

    logic clk, reset;
    logic [NR-1:0]      req_valid, req_ready;
    logic [NR*KB-1:0]   req_k_len;
    logic               op_valid, op_ready;
    logic [REQ_BITS-1:0] data_owner, done_req;
    logic               cl_enable, cl_clear_acc, cl_load_weights, cl_compute_enable, cl_broadcast_mode;
    logic [ARR_BITS-1:0] cl_array_select, done_array, rd_array, rel_array;
    logic [NA-1:0]      cl_array_ready, array_busy;
    logic               done_valid, rd_valid, rd_ready, rd_err, rel_valid;
    logic [30:0]        outs;

    systolic_cluster_scheduler #(
        .NUM_REQ(NR), .NUM_ARRAYS(NA), .K_BITS(KB), .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_k_len(req_k_len), .req_ready(req_ready),
        .op_valid(op_valid), .op_ready(op_ready), .data_owner(data_owner),
        .cl_enable(cl_enable), .cl_array_select(cl_array_select),
        .cl_clear_acc(cl_clear_acc), .cl_load_weights(cl_load_weights),
        .cl_compute_enable(cl_compute_enable), .cl_broadcast_mode(cl_broadcast_mode),
        .cl_array_ready(cl_array_ready),
        .done_valid(done_valid), .done_req(done_req), .done_array(done_array),
        .rd_valid(rd_valid), .rd_array(rd_array), .rd_ready(rd_ready), .rd_err(rd_err),
        .rel_valid(rel_valid), .rel_array(rel_array), .array_busy(array_busy)
    );

    assign outs = {req_ready, op_ready, data_owner, cl_enable, cl_array_select,
                   cl_clear_acc, cl_load_weights, cl_compute_enable, cl_broadcast_mode,
                   done_valid, done_req, done_array, rd_ready, rd_err, array_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_rel_en = 1'b0;

    // Model: ownership state per array and the round-robin start point.
    arr_state_t m_arr [NA];
    int m_ptr;

    function automatic logic [NA-1:0] m_busy();
        logic [NA-1:0] b = '0;
        for (int i = 0; i < NA; i++) b[i] = (m_arr[i] != FREE);
        return b;
    endfunction

    function automatic int m_free_lowest();
        for (int i = 0; i < NA; i++) if (m_arr[i] == FREE) return i;
        return -1;
    endfunction

    function automatic int m_winner(input logic [NR-1:0] mask);
        for (int o = 0; o < NR; o++) begin
            int r = (m_ptr + o) % NR;
            if (mask[r[1:0]]) return r;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        chk("array_busy", 32'(array_busy), 32'(m_busy()));
    endtask

    // Advance to just after the next rising edge; retire any release
    // issued during the finished cycle into the model.
    task automatic adv();
        @(posedge clk);
        #1;
        if (rel_valid && m_arr[rel_array] == HELD) m_arr[rel_array] = FREE;
        rel_valid = 1'b0;
        if (rand_rel_en && $urandom_range(0, 3) == 0) begin
            rel_valid = 1'b1;
            rel_array = ARR_BITS'($urandom_range(0, NA - 1));
        end
    endtask

    task automatic run_job(input logic [NR-1:0] mask, input logic [NR*KB-1:0] klanes,
                           input logic [15:0] pat, input int rdy, input int win, input int arr);
        logic [NR-1:0] g;
        int  k, beats;
        bit  loaded, fin, ov, e;
        g = NR'(1) << win;
        k = int'(KB'(klanes >> (win * KB)));
        req_valid = mask;
        req_k_len = klanes;
        sample();
        chk("grant", 32'(req_ready), 32'(g));
        adv();
        req_valid = '0;
        m_arr[arr] = BUSY;
        m_ptr = (win + 1) % NR;
        sample();
        chk("clear_acc", 32'(cl_clear_acc), 1);
        chk("clear_enable", 32'(cl_enable), 1);
        chk("clear_select", 32'(cl_array_select), arr);
        chk("clear_owner", 32'(data_owner), win);
        chk("clear_op_ready", 32'(op_ready), 0);
        adv();
        loaded = 1'b0; fin = 1'b0; beats = 0;
        for (int i = 0; i < 64 && !fin; i++) begin
            ov = (i < 16) ? pat[i[3:0]] : 1'b1;
            op_valid = ov;
            sample();
            chk("op_ready", 32'(op_ready), 1);
            chk("op_select", 32'(cl_array_select), arr);
            chk("op_owner", 32'(data_owner), win);
            chk("load_weights", 32'(cl_load_weights), loaded ? 0 : int'(ov));
            chk("compute_enable", 32'(cl_compute_enable), loaded ? int'(ov) : 0);
            chk("op_cl_enable", 32'(cl_enable), loaded ? 1 : int'(ov));
            adv();
            if (ov) begin
                if (!loaded) begin
                    loaded = 1'b1;
                    fin = (k == 0);
                end else begin
                    beats++;
                    fin = (beats == k);
                end
            end
        end
        if (!fin) chk("op_phase_timeout", 0, 1);
        op_valid = 1'b0;
        fin = 1'b0;
        for (int d = 1; d <= 32 && !fin; d++) begin
            cl_array_ready = (d > rdy) ? (NA'(1) << arr) : '0;
            sample();
            e = (d >= DC) && (d > rdy);
            chk("done_valid", 32'(done_valid), int'(e));
            chk("drain_enable", 32'(cl_enable), 1);
            chk("drain_select", 32'(cl_array_select), arr);
            chk("drain_op_ready", 32'(op_ready), 0);
            if (e) begin
                chk("done_req", 32'(done_req), win);
                chk("done_array", 32'(done_array), arr);
            end
            adv();
            fin = e;
        end
        cl_array_ready = '0;
        m_arr[arr] = HELD;
    endtask

    task automatic do_read(input int a, input logic [NR-1:0] mask);
        int held;
        held = (m_arr[a] == HELD) ? 1 : 0;
        rd_valid  = 1'b1;
        rd_array  = ARR_BITS'(a);
        req_valid = mask;
        sample();
        chk("rd_err", 32'(rd_err), held ? 0 : 1);
        chk("rd_priority_no_grant", 32'(req_ready), 0);
        chk("rd_ready_early", 32'(rd_ready), 0);
        adv();
        rd_valid  = 1'b0;
        req_valid = '0;
        sample();
        chk("rd_ready", 32'(rd_ready), held);
        chk("rd_err_clear", 32'(rd_err), 0);
        if (held != 0) begin
            chk("rd_select", 32'(cl_array_select), a);
            chk("rd_cl_enable", 32'(cl_enable), 0);
        end
        adv();
    endtask

    task automatic do_release(input int a);
        rel_valid = 1'b1;
        rel_array = ARR_BITS'(a);
        sample();
        adv();
    endtask

    typedef struct {
        logic [NR-1:0] mask;
        logic [KB-1:0] k;
        logic [15:0]   pat;
        int            rdy;
        int            win;
        int            arr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        // Fields: mask, k_len, op_valid pattern from LOAD (LSB first), ready delay, winner, array.
        tbl[0] = '{4'b1111, 8'd3, 16'hFFFF, 0, 0, 0};
        tbl[1] = '{4'b1111, 8'd3, 16'h0033, 0, 1, 1};
        tbl[2] = '{4'b1111, 8'd0, 16'h0004, 3, 2, 2};
        tbl[3] = '{4'b1111, 8'd1, 16'hFFFF, 0, 3, 3};
        tbl[4] = '{4'b1111, 8'd2, 16'h000D, 1, 0, 4};
        tbl[5] = '{4'b0100, 8'd1, 16'hFFFF, 0, 2, 5};
        tbl[6] = '{4'b0011, 8'd4, 16'hFFFF, 0, 0, 6};
        tbl[7] = '{4'b1000, 8'd1, 16'hFFFF, 0, 3, 7};

        for (int i = 0; i < NA; i++) m_arr[i] = FREE;
        m_ptr = 0;
        reset = 1'b0;
        req_valid = '1;
        req_k_len = '0;
        op_valid = 1'b0;
        cl_array_ready = '0;
        rd_valid = 1'b0; rd_array = '0;
        rel_valid = 1'b0; rel_array = '0;

        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("reset_outputs", 32'(outs), 0);
            adv();
        end
        reset = 1'b1;
        req_valid = '0;

        for (int i = 0; i < 8; i++)
            run_job(tbl[i].mask, {NR{tbl[i].k}}, tbl[i].pat, tbl[i].rdy, tbl[i].win, tbl[i].arr);

        req_valid = '1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("no_grant_all_held", 32'(req_ready), 0);
            adv();
        end
        rel_valid = 1'b1;
        rel_array = ARR_BITS'(5);
        sample();
        chk("no_same_cycle_alloc", 32'(req_ready), 0);
        adv();
        run_job(4'b1111, {NR{8'd2}}, 16'hFFFF, 0, 0, 5);

        do_read(3, 4'b1111);
        do_release(2);
        do_read(2, 4'b1111);
        for (int i = 0; i < NA; i++) do_release(i);

        req_valid = 4'b0001;
        req_k_len = {NR{8'd5}};
        sample();
        chk("mid_grant", 32'(req_ready), 1);
        adv();
        req_valid = '0;
        m_arr[0] = BUSY;
        sample();
        adv();
        op_valid = 1'b1;
        sample();
        chk("mid_load", 32'(cl_load_weights), 1);
        adv();
        sample();
        chk("mid_compute", 32'(cl_compute_enable), 1);
        reset = 1'b0;
        adv();
        reset = 1'b1;
        op_valid = 1'b0;
        for (int i = 0; i < NA; i++) m_arr[i] = FREE;
        m_ptr = 0;
        sample();
        chk("post_reset_outputs", 32'(outs), 0);
        adv();
        run_job(4'b1111, {NR{8'd1}}, 16'hFFFF, 0, 0, 0);

        rand_rel_en = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int op;
            op = $urandom_range(0, 3);
            if (op >= 2 && m_free_lowest() >= 0) begin
                logic [NR-1:0]    mask;
                logic [NR*KB-1:0] kl;
                logic [15:0]      pat;
                mask = NR'($urandom_range(1, 15));
                kl = '0;
                for (int j = 0; j < NR; j++)
                    kl = (kl << KB) | (NR*KB)'($urandom_range(0, 4));
                pat = 16'($urandom | $urandom);
                run_job(mask, kl, pat, $urandom_range(0, 3), m_winner(mask), m_free_lowest());
            end else if (op == 0) begin
                do_read($urandom_range(0, NA - 1), NR'($urandom_range(0, 15)));
            end else begin
                do_release($urandom_range(0, NA - 1));
            end
        end
        rand_rel_en = 1'b0;
        sample();
        adv();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_cluster_scheduler.md
Name: systolic_cluster_scheduler

Overview:
Job scheduler and sequencer for the multi-array systolic cluster.
- Arbitrates tile-matmul jobs from NUM_REQ requesters (round-robin).
- Allocates a free array and sequences it through clear, weight load, K-beat compute and drain.
- Tracks per-array ownership until the owner reads the results out and releases the array.
- Drives the cluster control pins, always in non-broadcast mode, and the operand-mux select for the upstream datapath.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
NUM_ARRAYS, 8, arrays in the cluster
K_BITS, 8, width of the per-job compute-beat count
DRAIN_CYCLES, 2, minimum cycles in DRAIN after the last compute beat

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge)
req_valid  in  NUM_REQ  job request per requester
req_k_len  in  NUM_REQ*K_BITS  compute beats per job; requester i uses slice [i*K_BITS +: K_BITS]
req_ready  out  NUM_REQ  one-hot, 1-cycle grant pulse
op_valid  in  1  operand beat valid from the muxed requester: b bus in LOAD, a bus in COMPUTE
op_ready  out  1  scheduler accepts an operand beat
data_owner  out  max(1,$clog2(NUM_REQ))  requester whose operands drive the cluster buses
cl_enable  out  1  cluster enable
cl_array_select  out  $clog2(NUM_ARRAYS)  cluster array_select
cl_clear_acc  out  1  cluster clear_acc
cl_load_weights  out  1  cluster load_weights
cl_compute_enable  out  1  cluster compute_enable
cl_broadcast_mode  out  1  tied 0
cl_array_ready  in  NUM_ARRAYS  cluster all_ready
done_valid  out  1  1-cycle job-complete pulse
done_req  out  max(1,$clog2(NUM_REQ))  owner of the completed job
done_array  out  $clog2(NUM_ARRAYS)  array holding the completed job's results
rd_valid  in  1  result-read request
rd_array  in  $clog2(NUM_ARRAYS)  array to read
rd_ready  out  1  results valid on the cluster results bus this cycle
rd_err  out  1  read targeted an array not in HELD
rel_valid  in  1  release request
rel_array  in  $clog2(NUM_ARRAYS)  array to release
array_busy  out  NUM_ARRAYS  1 = array is BUSY or HELD

Behaviour:
- Reset: state IDLE; every array FREE; round-robin pointer 0; every output 0.
- Per-array state: FREE -> BUSY (on grant) -> HELD (on done) -> FREE (on release).
- Controller states: IDLE, CLEAR, LOAD, COMPUTE, DRAIN, READ.
- IDLE priority is read first, then new job.
  - Read, target HELD: go to READ.
  - Read, target not HELD: 1-cycle rd_err pulse; stay IDLE.
  - New job: needs >=1 req_valid and >=1 FREE array.
    - Winner = first requester at or after the RR pointer.
    - Pulse req_ready[winner]; latch winner id, its k_len, and the lowest-index FREE array (mark it BUSY).
    - RR pointer <= winner+1 mod NUM_REQ. Next state CLEAR.
  - No FREE array: req_ready stays 0; requests wait.
- READ: 1 cycle. cl_array_select=rd_array, cl_enable=0, rd_ready=1. Next state IDLE. Array stays HELD.
- CLEAR: 1 cycle. cl_enable=1, cl_clear_acc=1. Next state LOAD.
- LOAD: op_ready=1; cl_load_weights=op_valid; cl_enable=op_valid. Waits indefinitely. On a beat:
  - k_len==0: go to DRAIN (result is a cleared accumulator).
  - otherwise: go to COMPUTE.
- COMPUTE: op_ready=1; cl_compute_enable=op_valid; cl_enable=1.
  - Each accepted beat decrements the remaining count. Stalls (op_valid=0) are legal.
  - After the k_len-th beat, go to DRAIN.
- DRAIN: cl_enable=1, all other controls 0.
  - Exit when at least DRAIN_CYCLES cycles have elapsed AND cl_array_ready[sel]=1.
  - On exit: done_valid=1 with done_req/done_array; array -> HELD; next state IDLE.
- cl_array_select: the allocated array from CLEAR through DRAIN; rd_array in READ; otherwise 0.
- data_owner = latched winner from CLEAR through COMPUTE.
- Release: accepted in any state.
  - rel_valid with rel_array HELD: that array is FREE from the next cycle.
  - Release of a FREE or BUSY array is ignored.
  - A released array is allocatable in the cycle after release, never the same cycle.
- Latency: grant to first op_ready is 2 cycles (CLEAR, then LOAD).
- Reset asserted mid-job: immediate return to the reset state. The in-flight job is dropped with no done; all arrays return to FREE.

Decomposition:
- Package systolic_sched_pkg:
  - sched_state_t enum: IDLE, CLEAR, LOAD, COMPUTE, DRAIN, READ.
  - arr_state_t enum: FREE, BUSY, HELD.
  - Width localparams: REQ_BITS = max(1,$clog2(NUM_REQ)); ARR_BITS.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and pointer; outputs one-hot grant and grant index. Purely combinational; the pointer register lives in the scheduler.

Test Plan:
- Reset=0 for 2 cycles with req_valid=4'b1111 -> no grant; all outputs 0; array_busy=0.
- Req0 with k_len=3, op_valid held 1 -> req_ready[0] at t0; clear_acc at t1; load at t2; compute_enable at t3–t5; done_valid with done_array=0 once ≥2 DRAIN cycles elapsed and ready=1.
- req_valid=1111 held, 8 FREE arrays -> grants in order 0,1,2,3,0; arrays allocated 0,1,2,3,4.
- Compute with op_valid pattern 1,0,0,1,1 (k_len=3) -> compute_enable follows op_valid; exactly 3 beats counted.
- All 8 arrays HELD -> no grant. Release of array 5 -> next grant allocates array 5. Read of FREE array 2 -> rd_err pulse, no rd_ready.
- Reset dropped to 0 during COMPUTE -> next cycle IDLE; array_busy=0; no done_valid.
